// File: rtl/csr_file.sv
// csr_file: machine-mode CSR register file for the single-cycle RV64 core.
//
// Implemented CSRs: mstatus (0x300), mtvec (0x305), mepc (0x341),
// mcause (0x342), and optionally mscratch (0x340) when the macro
// CSR_MSCRATCH_EN is defined. Without the macro, 0x340 is unimplemented.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_ren/i_raddr/o_rdata   combinational read port (0 when disabled/unimplemented)
//   i_wen/i_waddr/i_wdata   general synchronous write port (CSRRW/S/C results)
//   i_mepc_*, i_mcause_*,
//   i_mstatus_*             trap-update ports; these win over a general
//                           write to the same CSR in the same cycle
//   o_mtvec/o_mstatus/o_mepc continuous register views for the PC unit
module csr_file #(
  parameter int          XLEN        = 64,
  parameter int          CSR_ADDRW   = 12,
  parameter logic [63:0] MSTATUS_RST = 64'h0000_000a_0000_1800
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ren,
  input  logic [CSR_ADDRW-1:0] i_raddr,
  output logic [XLEN-1:0]      o_rdata,
  input  logic                 i_wen,
  input  logic [CSR_ADDRW-1:0] i_waddr,
  input  logic [XLEN-1:0]      i_wdata,
  input  logic                 i_mepc_wen,
  input  logic [XLEN-1:0]      i_mepc_wdata,
  input  logic                 i_mcause_wen,
  input  logic [XLEN-1:0]      i_mcause_wdata,
  input  logic                 i_mstatus_wen,
  input  logic [XLEN-1:0]      i_mstatus_wdata,
  output logic [XLEN-1:0]      o_mtvec,
  output logic [XLEN-1:0]      o_mstatus,
  output logic [XLEN-1:0]      o_mepc
);

  localparam logic [CSR_ADDRW-1:0] ADDR_MSTATUS  = CSR_ADDRW'('h300);
  localparam logic [CSR_ADDRW-1:0] ADDR_MTVEC    = CSR_ADDRW'('h305);
  localparam logic [CSR_ADDRW-1:0] ADDR_MSCRATCH = CSR_ADDRW'('h340);
  localparam logic [CSR_ADDRW-1:0] ADDR_MEPC     = CSR_ADDRW'('h341);
  localparam logic [CSR_ADDRW-1:0] ADDR_MCAUSE   = CSR_ADDRW'('h342);

  logic [XLEN-1:0] mstatus, mtvec, mepc, mcause;

  // General-port address decode; trap ports are handled separately.
  logic gw_mstatus, gw_mtvec, gw_mepc, gw_mcause;
  assign gw_mstatus = i_wen && (i_waddr == ADDR_MSTATUS);
  assign gw_mtvec   = i_wen && (i_waddr == ADDR_MTVEC);
  assign gw_mepc    = i_wen && (i_waddr == ADDR_MEPC);
  assign gw_mcause  = i_wen && (i_waddr == ADDR_MCAUSE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mstatus <= XLEN'(MSTATUS_RST);
      mtvec   <= '0;
      mepc    <= '0;
      mcause  <= '0;
    end else begin
      if (gw_mtvec) mtvec <= i_wdata;
      // Trap update is checked first so it takes priority on a collision.
      if (i_mstatus_wen)   mstatus <= i_mstatus_wdata;
      else if (gw_mstatus) mstatus <= i_wdata;
      if (i_mepc_wen)      mepc    <= i_mepc_wdata;
      else if (gw_mepc)    mepc    <= i_wdata;
      if (i_mcause_wen)    mcause  <= i_mcause_wdata;
      else if (gw_mcause)  mcause  <= i_wdata;
    end
  end

`ifdef CSR_MSCRATCH_EN
  logic [XLEN-1:0] mscratch;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                   mscratch <= '0;
    else if (i_wen && i_waddr == ADDR_MSCRATCH)  mscratch <= i_wdata;
  end
`endif

  always_comb begin
    o_rdata = '0;
    if (i_ren) begin
      case (i_raddr)
        ADDR_MSTATUS:  o_rdata = mstatus;
        ADDR_MTVEC:    o_rdata = mtvec;
        ADDR_MEPC:     o_rdata = mepc;
        ADDR_MCAUSE:   o_rdata = mcause;
`ifdef CSR_MSCRATCH_EN
        ADDR_MSCRATCH: o_rdata = mscratch;
`endif
        default:       o_rdata = '0;
      endcase
    end
  end

  assign o_mtvec   = mtvec;
  assign o_mstatus = mstatus;
  assign o_mepc    = mepc;

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: randomized self-checking bench for csr_file. A reference
// model keeps CSR contents in an associative array keyed by address and
// applies the write rules (general write, then trap writes override).
module tb_csr_file;
  localparam logic [63:0] MST_RST = 64'h0000_000a_0000_1800;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_ren;
  logic [11:0] i_raddr;
  logic [63:0] o_rdata;
  logic        i_wen;
  logic [11:0] i_waddr;
  logic [63:0] i_wdata;
  logic        i_mepc_wen, i_mcause_wen, i_mstatus_wen;
  logic [63:0] i_mepc_wdata, i_mcause_wdata, i_mstatus_wdata;
  logic [63:0] o_mtvec, o_mstatus, o_mepc;

  always #5 i_clk = ~i_clk;

  csr_file dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ren(i_ren), .i_raddr(i_raddr), .o_rdata(o_rdata),
    .i_wen(i_wen), .i_waddr(i_waddr), .i_wdata(i_wdata),
    .i_mepc_wen(i_mepc_wen), .i_mepc_wdata(i_mepc_wdata),
    .i_mcause_wen(i_mcause_wen), .i_mcause_wdata(i_mcause_wdata),
    .i_mstatus_wen(i_mstatus_wen), .i_mstatus_wdata(i_mstatus_wdata),
    .o_mtvec(o_mtvec), .o_mstatus(o_mstatus), .o_mepc(o_mepc)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] mdl [int];

  function automatic bit implemented(input int a);
`ifdef CSR_MSCRATCH_EN
    if (a == 'h340) return 1'b1;
`endif
    return (a == 'h300 || a == 'h305 || a == 'h341 || a == 'h342);
  endfunction

  task automatic mdl_reset();
    mdl.delete();
    mdl['h300] = MST_RST;
    mdl['h305] = 64'd0;
    mdl['h340] = 64'd0;
    mdl['h341] = 64'd0;
    mdl['h342] = 64'd0;
  endtask

  function automatic logic [63:0] mdl_read(input bit en, input int a);
    if (!en || !implemented(a)) return 64'd0;
    return mdl[a];
  endfunction

  task automatic mdl_clock();
    if (i_wen && implemented(int'(i_waddr))) mdl[int'(i_waddr)] = i_wdata;
    if (i_mepc_wen)    mdl['h341] = i_mepc_wdata;
    if (i_mcause_wen)  mdl['h342] = i_mcause_wdata;
    if (i_mstatus_wen) mdl['h300] = i_mstatus_wdata;
  endtask

  task automatic idle();
    i_ren = 0; i_raddr = '0; i_wen = 0; i_waddr = '0; i_wdata = '0;
    i_mepc_wen = 0; i_mcause_wen = 0; i_mstatus_wen = 0;
    i_mepc_wdata = '0; i_mcause_wdata = '0; i_mstatus_wdata = '0;
  endtask

  task automatic check_views(input string tag);
    chk({tag, ".rdata"},   o_rdata,   mdl_read(i_ren, int'(i_raddr)));
    chk({tag, ".mtvec"},   o_mtvec,   mdl['h305]);
    chk({tag, ".mstatus"}, o_mstatus, mdl['h300]);
    chk({tag, ".mepc"},    o_mepc,    mdl['h341]);
  endtask

  // Checks old values before the edge, clocks, updates model, checks after.
  task automatic step(input string tag);
    @(negedge i_clk);
    check_views({tag, ".pre"});
    @(posedge i_clk);
    mdl_clock();
    #1;
    check_views({tag, ".post"});
  endtask

  task automatic rd(input int a, input logic [63:0] exp, input string tag);
    i_ren = 1; i_raddr = 12'(a);
    #1;
    chk(tag, o_rdata, exp);
  endtask

  initial begin
    idle();
    i_rst = 1;
    mdl_reset();
    #1;
    // Reset values, no clock edge required.
    rd('h300, MST_RST, "rst.mstatus");
    rd('h305, 64'd0,   "rst.mtvec");
    rd('h341, 64'd0,   "rst.mepc");
    rd('h342, 64'd0,   "rst.mcause");
    chk("rst.o_mtvec", o_mtvec, 64'd0);
    chk("rst.o_mepc",  o_mepc,  64'd0);
    chk("rst.o_mstatus", o_mstatus, MST_RST);
    @(posedge i_clk); #1;
    i_rst = 0;

    // General write to mtvec; read the same address during the write.
    idle();
    i_wen = 1; i_waddr = 12'h305; i_wdata = 64'h8000_0100;
    i_ren = 1; i_raddr = 12'h305;
    step("gw.mtvec");
    idle();
    rd('h305, 64'h8000_0100, "gw.mtvec.rb");
    chk("gw.o_mtvec", o_mtvec, 64'h8000_0100);

    // Ecall-style trap update of all three trap ports.
    idle();
    i_mepc_wen = 1;    i_mepc_wdata = 64'h8000_0044;
    i_mcause_wen = 1;  i_mcause_wdata = 64'd11;
    i_mstatus_wen = 1; i_mstatus_wdata = 64'h0000_000a_0000_1880;
    step("trap");
    idle();
    rd('h342, 64'd11, "trap.mcause");
    chk("trap.o_mepc", o_mepc, 64'h8000_0044);
    chk("trap.o_mstatus", o_mstatus, 64'h0000_000a_0000_1880);

    // Collision: trap write beats general write to the same CSR.
    idle();
    i_wen = 1; i_waddr = 12'h341; i_wdata = 64'h1234;
    i_mepc_wen = 1; i_mepc_wdata = 64'h5678;
    step("coll");
    idle();
    rd('h341, 64'h5678, "coll.mepc");

    // General write to a different CSR proceeds alongside a trap write.
    idle();
    i_wen = 1; i_waddr = 12'h342; i_wdata = 64'h77;
    i_mepc_wen = 1; i_mepc_wdata = 64'h9abc;
    step("par");
    idle();
    rd('h342, 64'h77, "par.mcause");

    // Read gating and unimplemented address.
    idle();
    i_ren = 0; i_raddr = 12'h300; #1;
    chk("gate.ren0", o_rdata, 64'd0);
    i_wen = 1; i_waddr = 12'h7c0; i_wdata = 64'hdead;
    step("unimpl");
    idle();
    rd('h7c0, 64'd0, "unimpl.rd");
    rd('h300, mdl['h300], "unimpl.mstatus");
    rd('h305, mdl['h305], "unimpl.mtvec");

    // mscratch: implemented only with the macro; model decides.
    idle();
    i_wen = 1; i_waddr = 12'h340; i_wdata = 64'habcd;
    step("mscr");
    idle();
`ifdef CSR_MSCRATCH_EN
    rd('h340, 64'habcd, "mscr.rd");
`else
    rd('h340, 64'd0, "mscr.rd");
`endif

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      int sel;
      int addrs[6] = '{'h300, 'h305, 'h340, 'h341, 'h342, 'h7c0};
      idle();
      sel = $urandom_range(0, 6);
      i_ren   = 1'($urandom_range(0, 3) != 0);
      i_raddr = (sel == 6) ? 12'($urandom) : 12'(addrs[sel]);
      sel = $urandom_range(0, 6);
      i_wen   = 1'($urandom_range(0, 1));
      i_waddr = (sel == 6) ? 12'($urandom) : 12'(addrs[sel]);
      i_wdata = {$urandom, $urandom};
      i_mepc_wen    = 1'($urandom_range(0, 4) == 0);
      i_mcause_wen  = 1'($urandom_range(0, 4) == 0);
      i_mstatus_wen = 1'($urandom_range(0, 4) == 0);
      i_mepc_wdata    = {$urandom, $urandom};
      i_mcause_wdata  = {$urandom, $urandom};
      i_mstatus_wdata = {$urandom, $urandom};
      step("rnd");
    end

    // Asynchronous reset mid-cycle with a write pending.
    idle();
    i_wen = 1; i_waddr = 12'h305; i_wdata = 64'h1111;
    i_mepc_wen = 1; i_mepc_wdata = 64'h2222;
    @(negedge i_clk);
    i_rst = 1;
    mdl_reset();
    #1;
    chk("arst.o_mtvec", o_mtvec, 64'd0);
    chk("arst.o_mepc", o_mepc, 64'd0);
    chk("arst.o_mstatus", o_mstatus, MST_RST);
    @(posedge i_clk); #1;
    chk("arst.hold.mtvec", o_mtvec, 64'd0);
    chk("arst.hold.mepc", o_mepc, 64'd0);
    idle();
    i_rst = 0;
    rd('h342, 64'd0, "arst.mcause");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
